// File: rtl/led_chain_ctrl_if.sv
// Pixel-memory read port plus the word handshake towards the serial LED driver.
// The controller drives the master side; memory and driver sit on the slave side.
interface led_chain_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;
    logic              drv_ready;
    logic [23:0]       drv_rgb;
    logic              drv_busy;
    logic              drv_latched;

    modport master (
        output pix_addr, drv_ready, drv_rgb,
        input  pix_data, drv_busy, drv_latched
    );

    modport slave (
        input  pix_addr, drv_ready, drv_rgb,
        output pix_data, drv_busy, drv_latched
    );
endinterface

// File: rtl/led_chain_ctrl.sv
// LED chain frame controller: walks the pixel memory, scales each pixel by a
// global brightness, hands words to the serial driver one at a time, then waits
// for the driver's latch/reset period before reporting the frame as done.
// Frames start on request or from a periodic auto-refresh timer.
module led_chain_ctrl #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int NUM_LEDS       = 8,
    parameter int REFRESH_CYCLES = 1_000_000,
    parameter int GRB_ORDER      = 1
) (
    input  logic                    clk,
    input  logic                    rst,        // synchronous, active low
    input  logic                    start,
    input  logic                    auto_en,
    input  logic [7:0]              brightness,
    led_chain_ctrl_if.master        bus,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    // 4 us of flush wait expressed in clk cycles (4*CLK_FREQ/1e6 without overflow).
    localparam int FLUSH_TIMEOUT = (CLK_FREQ / 250_000 > 0) ? CLK_FREQ / 250_000 : 1;
    localparam int TMO_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam int RT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_LEDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(FLUSH_TIMEOUT - 1);
    localparam logic [RT_W-1:0]   TIMER_LAST = RT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, SCALE, PRESENT, WAIT_LATCH, FLUSH, DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic [23:0]       drv_rgb_q;
    logic              drv_ready_q;
    logic              busy_q;
    logic              frame_done_q;
    logic [7:0]        bright_q;
    logic              flush_saw_q;
    logic [TMO_W-1:0]  flush_cnt_q;

    logic [RT_W-1:0]   timer_q, timer_d;
    logic              pending_q, pending_d;
    logic              launch;
    logic [23:0]       word_d;

    // Per-channel scale: c * (brightness + 1) >> 8, so 255 is identity and 0 is black.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    // Scaled/reordered word, frame launch decision and refresh-timer next state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        logic [7:0] r_s, g_s, b_s;
        r_s = scale8(bus.pix_data[23:16], bright_q);
        g_s = scale8(bus.pix_data[15:8],  bright_q);
        b_s = scale8(bus.pix_data[7:0],   bright_q);
        word_d = (GRB_ORDER != 0) ? {g_s, r_s, b_s} : {r_s, g_s, b_s};

        // A start request wins over a pending expiry; either way only one frame launches.
        launch = (state_q == IDLE) && (start || (auto_en && pending_q));

        timer_d   = '0;
        pending_d = 1'b0;
        if (auto_en) begin
            timer_d   = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
            pending_d = pending_q;
            if (launch)
                pending_d = 1'b0;
            else if (timer_q == TIMER_LAST)
                pending_d = 1'b1;
        end
    end

    // Refresh timer and the expiry-pending flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    // Frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            pix_addr_q   <= '0;
            drv_rgb_q    <= '0;
            drv_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            bright_q     <= '0;
            flush_saw_q  <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        bright_q   <= brightness;
                        pix_addr_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                // pix_data for pix_addr arrives one cycle after the address.
                FETCH: state_q <= SCALE;
                SCALE: begin
                    drv_rgb_q   <= word_d;
                    drv_ready_q <= 1'b1;
                    state_q     <= PRESENT;
                end
                PRESENT: state_q <= WAIT_LATCH;
                WAIT_LATCH: begin
                    if (bus.drv_latched) begin
                        if (pix_addr_q == LAST_ADDR) begin
                            // Dropping ready asks the driver for its latch/reset pulse.
                            drv_ready_q <= 1'b0;
                            flush_saw_q <= 1'b0;
                            flush_cnt_q <= '0;
                            state_q     <= FLUSH;
                        end else begin
                            pix_addr_q <= pix_addr_q + 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.drv_busy)
                        flush_saw_q <= 1'b1;
                    if (flush_cnt_q != TMO_LAST)
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    // Finish once busy has risen and fallen, or if it never rose in time.
                    if (!bus.drv_busy && (flush_saw_q || flush_cnt_q == TMO_LAST)) begin
                        frame_done_q <= 1'b1;
                        pix_addr_q   <= '0;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pix_addr  = pix_addr_q;
    assign bus.drv_rgb   = drv_rgb_q;
    assign bus.drv_ready = drv_ready_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_led_chain_ctrl.sv
// Bench for led_chain_ctrl: two instances (GRB and RGB order) share stimulus, each
// with a pixel memory and a simple LED driver model that captures presented words.
module tb_led_chain_ctrl;

    localparam int NL = 3;
    localparam int AW = 2;
    localparam int RC = 5000;
    localparam int CF = 50_000_000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] brightness = 8'd0;
    logic       busy_en = 1'b1;
    logic       cap_clr = 1'b0;
    logic [23:0] mem [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 2; g++) begin : inst
        led_chain_ctrl_if #(.ADDR_W(AW)) bus ();
        logic        busy;
        logic        frame_done;
        logic [23:0] cap [8];
        int          cap_n = 0;
        int          fd_cnt = 0;
        int          hold = 0;

        led_chain_ctrl #(
            .CLK_FREQ(CF), .NUM_LEDS(NL), .REFRESH_CYCLES(RC), .GRB_ORDER(g == 0 ? 1 : 0)
        ) dut (
            .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
            .brightness(brightness), .bus(bus.master),
            .busy(busy), .frame_done(frame_done)
        );

        // Pixel memory with one cycle of read latency.
        always @(posedge clk) bus.pix_data <= mem[bus.pix_addr];

        // Driver model: capture a word when ready and idle, pulse latched, stay busy a while.
        always @(posedge clk) begin
            if (!rst) begin
                hold            <= 0;
                bus.drv_latched <= 1'b0;
                bus.drv_busy    <= 1'b0;
            end else begin
                bus.drv_latched <= 1'b0;
                if (hold != 0) hold <= hold - 1;
                if (hold == 1) bus.drv_busy <= 1'b0;
                if (bus.drv_ready && hold == 0) begin
                    if (cap_n < 8) cap[cap_n] <= bus.drv_rgb;
                    cap_n           <= cap_n + 1;
                    bus.drv_latched <= 1'b1;
                    bus.drv_busy    <= busy_en;
                    hold            <= 12;
                end
            end
            if (frame_done) fd_cnt <= fd_cnt + 1;
            if (cap_clr) begin
                cap_n  <= 0;
                fd_cnt <= 0;
            end
        end
    end

    typedef struct {
        logic [7:0]  b;
        logic [71:0] px;     // {pixel0, pixel1, pixel2}
        logic [71:0] e_grb;
        logic [71:0] e_rgb;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait budget expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_caps();
        cap_clr = 1'b1;
        tick(1);
        cap_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic load_mem(input logic [71:0] px);
        mem[0] = px[71:48];
        mem[1] = px[47:24];
        mem[2] = px[23:0];
        mem[3] = 24'h0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((inst[0].fd_cnt == 0 || inst[1].fd_cnt == 0) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) timeout_fail(name);
    endtask

    task automatic wait_caps0(input string name, input int want, input int budget);
        int n = 0;
        while (inst[0].cap_n < want && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) timeout_fail(name);
    endtask

    task automatic check_zero(input string tag, input logic rdy, input logic [23:0] rgb,
                              input logic [AW-1:0] addr, input logic bsy, input logic fd);
        check({tag, "_ready"}, rdy, 0);
        check({tag, "_rgb"}, rgb, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_busy"}, bsy, 0);
        check({tag, "_frame_done"}, fd, 0);
    endtask

    task automatic check_frame(input string tag, input int n, input logic [23:0] w0,
                               input logic [23:0] w1, input logic [23:0] w2, input int fd,
                               input logic bsy, input logic rdy, input logic [AW-1:0] addr,
                               input logic [71:0] exp);
        check({tag, "_words"}, n, 3);
        check({tag, "_w0"}, w0, exp[71:48]);
        check({tag, "_w1"}, w1, exp[47:24]);
        check({tag, "_w2"}, w2, exp[23:0]);
        check({tag, "_frames"}, fd, 1);
        check({tag, "_busy_end"}, bsy, 0);
        check({tag, "_ready_end"}, rdy, 0);
        check({tag, "_addr_end"}, addr, 0);
    endtask

    task automatic check_both(input string tag, input int v);
        check_frame({tag, "_grb"}, inst[0].cap_n, inst[0].cap[0], inst[0].cap[1], inst[0].cap[2],
                    inst[0].fd_cnt, inst[0].busy, inst[0].bus.drv_ready, inst[0].bus.pix_addr,
                    vt[v].e_grb);
        check_frame({tag, "_rgb"}, inst[1].cap_n, inst[1].cap[0], inst[1].cap[1], inst[1].cap[2],
                    inst[1].fd_cnt, inst[1].busy, inst[1].bus.drv_ready, inst[1].bus.pix_addr,
                    vt[v].e_rgb);
    endtask

    initial begin
        int n;
        int rise [3];
        int nr;
        logic prev_busy;

        vt[0] = '{8'd255, {24'hFF0000, 24'h00FF00, 24'h0000FF},
                          {24'h00FF00, 24'hFF0000, 24'h0000FF},
                          {24'hFF0000, 24'h00FF00, 24'h0000FF}};
        vt[1] = '{8'd127, {24'h80FF40, 24'h010203, 24'hFFFFFF},
                          {24'h7F4020, 24'h010001, 24'h7F7F7F},
                          {24'h407F20, 24'h000101, 24'h7F7F7F}};
        vt[2] = '{8'd0,   {24'hFFFFFF, 24'h123456, 24'hABCDEF},
                          {24'h000000, 24'h000000, 24'h000000},
                          {24'h000000, 24'h000000, 24'h000000}};
        vt[3] = '{8'd1,   {24'hFF807F, 24'h7F7F7F, 24'h00FF80},
                          {24'h010100, 24'h000000, 24'h010001},
                          {24'h010100, 24'h000000, 24'h000101}};
        vt[4] = '{8'd200, {24'h64C8FA, 24'h000000, 24'h0A0B0C},
                          {24'h9D4EC4, 24'h000000, 24'h080709},
                          {24'h4E9DC4, 24'h000000, 24'h070809}};

        load_mem(vt[0].px);

        // Reset state.
        rst = 1'b0;
        tick(3);
        check_zero("rst_grb", inst[0].bus.drv_ready, inst[0].bus.drv_rgb, inst[0].bus.pix_addr,
                   inst[0].busy, inst[0].frame_done);
        check_zero("rst_rgb", inst[1].bus.drv_ready, inst[1].bus.drv_rgb, inst[1].bus.pix_addr,
                   inst[1].busy, inst[1].frame_done);
        rst = 1'b1;
        tick(2);

        // Table-driven frames; brightness is changed right after launch and must not matter.
        for (int v = 0; v < 5; v++) begin
            load_mem(vt[v].px);
            brightness = vt[v].b;
            clear_caps();
            pulse_start();
            brightness = ~vt[v].b;
            wait_done($sformatf("vec%0d_done", v), 400);
            tick(3);
            check_both($sformatf("vec%0d", v), v);
        end

        // Ready drops on the cycle after the last latch is seen.
        load_mem(vt[0].px);
        brightness = 8'd255;
        clear_caps();
        pulse_start();
        wait_caps0("last_latch", 3, 200);
        check("last_latch_ready_hold", inst[0].bus.drv_ready, 1);
        check("last_latch_addr", inst[0].bus.pix_addr, 2);
        tick(1);
        check("last_latch_ready_drop", inst[0].bus.drv_ready, 0);
        check("last_latch_busy", inst[0].busy, 1);
        wait_done("last_latch_done", 200);
        tick(2);
        check("last_latch_frames", inst[0].fd_cnt, 1);

        // Start pulses mid-frame are ignored.
        clear_caps();
        pulse_start();
        tick(5);
        pulse_start();
        tick(10);
        pulse_start();
        wait_done("restart_done", 400);
        tick(60);
        check("restart_frames", inst[0].fd_cnt, 1);
        check("restart_words", inst[0].cap_n, 3);
        check("restart_idle", inst[0].busy, 0);

        // Driver never raises busy: frame completes after the 200-cycle flush timeout.
        busy_en = 1'b0;
        clear_caps();
        pulse_start();
        wait_caps0("tmo_last_latch", 3, 200);
        tick(1);
        n = 0;
        while (!inst[0].frame_done && n < 400) begin
            tick(1);
            n++;
        end
        check("flush_timeout_cycles", n, 200);
        busy_en = 1'b1;
        tick(5);
        check("flush_timeout_frames", inst[0].fd_cnt, 1);

        // Reset while waiting for the latch of pixel 1.
        clear_caps();
        pulse_start();
        n = 0;
        while (inst[0].bus.pix_addr != 2'd1 && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) timeout_fail("abort_reach_pixel1");
        tick(5);
        check("abort_words_before", inst[0].cap_n, 1);
        check("abort_ready_before", inst[0].bus.drv_ready, 1);
        rst = 1'b0;
        tick(1);
        check_zero("abort_grb", inst[0].bus.drv_ready, inst[0].bus.drv_rgb, inst[0].bus.pix_addr,
                   inst[0].busy, inst[0].frame_done);
        check_zero("abort_rgb", inst[1].bus.drv_ready, inst[1].bus.drv_rgb, inst[1].bus.pix_addr,
                   inst[1].busy, inst[1].frame_done);
        tick(3);
        rst = 1'b1;
        tick(2);
        check("abort_no_frame_done", inst[0].fd_cnt, 0);
        clear_caps();
        pulse_start();
        wait_done("after_abort_done", 400);
        tick(3);
        check_both("after_abort", 0);

        // Auto refresh: launches every RC cycles; start coincident with expiry gives one frame.
        clear_caps();
        auto_en = 1'b1;
        nr = 0;
        n = 0;
        prev_busy = inst[0].busy;
        while (nr < 3 && n < 16000) begin
            tick(1);
            n++;
            if (inst[0].busy && !prev_busy) begin
                rise[nr] = n;
                nr++;
            end
            prev_busy = inst[0].busy;
        end
        if (nr < 3) timeout_fail("auto_three_frames");
        else begin
            check("auto_period_1", rise[1] - rise[0], RC);
            check("auto_period_2", rise[2] - rise[1], RC);
            check("auto_frames_so_far", inst[0].fd_cnt, 2);
            tick(RC - 3);
            clear_caps();
            pulse_start();
            check("coincident_launch", inst[0].busy, 1);
            wait_done("coincident_done", 400);
            tick(100);
            check("coincident_frames", inst[0].fd_cnt, 1);
            check("coincident_idle", inst[0].busy, 0);
        end
        auto_en = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_chain_ctrl.md
LED_CHAIN_CTRL -- requirements
Module: led_chain_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter NUM_LEDS, default 8: number of pixels in the chain (range 1..1024).
REQ-003 Parameter REFRESH_CYCLES, default 1_000_000: auto-refresh period in clk cycles (20 ms at 50 MHz).
REQ-004 Parameter GRB_ORDER, default 1: 1 = emit {G,R,B}; 0 = emit {R,G,B}.
REQ-005 clk  input  1  system clock; all logic is rising-edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to send one frame.
REQ-008 auto_en  input  1  enable periodic frame refresh.
REQ-009 brightness  input  8  global scale, sampled at frame start.
REQ-010 pix_addr  output  $clog2(NUM_LEDS) (min 1)  pixel memory read address.
REQ-011 pix_data  input  24  pixel {R,G,B}, valid exactly one cycle after pix_addr is presented.
REQ-012 drv_ready  output  1  to led_driver ready; high = transmit, low = latch/reset pulse.
REQ-013 drv_rgb  output  24  to led_driver rgb_data.
REQ-014 drv_busy  input  1  from led_driver busy.
REQ-015 drv_latched  input  1  from led_driver data_latched; one-cycle pulse when the word is captured.
REQ-016 busy  output  1  high while a frame is in progress.
REQ-017 frame_done  output  1  one-cycle pulse when a frame, including the latch pulse, completes.

Function
REQ-018 States: IDLE, FETCH, SCALE, PRESENT, WAIT_LATCH, FLUSH, DONE.
REQ-019 IDLE -> FETCH on start=1, or on auto_en=1 with refresh timer expired; brightness is registered and pix_addr is set to 0 on that transition.
REQ-020 Start has priority over timer expiry in the same cycle; exactly one frame is launched.
REQ-021 Start is ignored when not in IDLE; no queuing.
REQ-022 FETCH lasts 1 cycle, waiting for memory latency; SCALE registers the scaled word into drv_rgb after 1 cycle.
REQ-023 Scaling per channel: out = (c * (brightness_reg + 1)) >> 8, 16-bit intermediate, truncated to 8 bits. brightness 255 is identity; brightness 0 gives all zero.
REQ-024 Channel order follows GRB_ORDER, applied after scaling.
REQ-025 PRESENT: drv_ready=1 and drv_rgb stable; move to WAIT_LATCH.
REQ-026 WAIT_LATCH: hold drv_ready=1 and drv_rgb until drv_latched=1.
REQ-027 On drv_latched with pix_addr < NUM_LEDS-1: increment pix_addr, go to FETCH, keep drv_ready=1. The next word is in drv_rgb within 3 cycles of the latch.
REQ-028 On drv_latched with pix_addr = NUM_LEDS-1: drv_ready goes to 0 on the next cycle, pix_addr stays, go to FLUSH.
REQ-029 FLUSH: wait until drv_busy has been observed 1 and then 0; then go to DONE.
REQ-030 FLUSH timeout: if drv_busy stays 0 for 4*CLK_FREQ/1_000_000 cycles after entry, proceed to DONE anyway.
REQ-031 DONE: frame_done=1 for one cycle, pix_addr returns to 0, go to IDLE.
REQ-032 busy=1 in every state except IDLE.
REQ-033 Refresh timer counts 0..REFRESH_CYCLES-1 every cycle while auto_en=1, and is held at 0 while auto_en=0.
REQ-034 Expiry is recorded as a pending flag; the flag clears when a frame launches or when auto_en=0.
REQ-035 drv_ready is low in IDLE, FLUSH and DONE.
REQ-036 drv_latched arriving outside WAIT_LATCH is ignored.
REQ-037 NUM_LEDS=1: the first latch goes directly to FLUSH.

Reset
REQ-038 While rst=0 at a clock edge, all outputs are 0: drv_ready, drv_rgb, pix_addr, busy, frame_done.
REQ-039 Reset also sets state=IDLE and clears the refresh timer, pending flag and brightness_reg.
REQ-040 Reset mid-frame aborts immediately; no frame_done is produced.

Verification
REQ-041 NUM_LEDS=3, memory {FF0000, 00FF00, 0000FF}, brightness 255, GRB_ORDER=1, start pulse, bench driver model -> drv_rgb sequence 00FF00, FF0000, 0000FF; drv_ready falls after the third latch; one frame_done.
REQ-042 brightness 127, pixel 80FF40 (GRB_ORDER=0) -> drv_rgb 407F20.
REQ-043 brightness 0 -> every drv_rgb word is 000000; frame still completes with frame_done.
REQ-044 auto_en=1, REFRESH_CYCLES=5000, no start -> a frame launches every 5000 cycles while idle. A start pulse coincident with expiry -> exactly one frame.
REQ-045 start repeated mid-frame -> ignored, exactly one frame_done. drv_busy held 0 in FLUSH -> frame_done after the 200-cycle timeout.
REQ-046 rst=0 asserted during WAIT_LATCH of pixel 1 -> next cycle all outputs 0 and state IDLE; a following start sends a full frame from pixel 0.
